// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, controller states and the iteration counter width.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Final sign correction for the iterative datapath. The core loop always
// works on magnitudes; this block turns the unsigned result back into the
// signed HI/LO pair (whole 64-bit product, or quotient and remainder
// separately).
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic           isMult_i,
    input  logic           negProd_i,
    input  logic           negQuo_i,
    input  logic           negRem_i,
    input  logic [2*W-1:0] work_i,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o
);

    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;

    // Negate the product as a single 64-bit value, or the division fields individually
    always_comb begin
        prod = negProd_i ? -work_i : work_i;
        quo  = negQuo_i ? -work_i[W-1:0] : work_i[W-1:0];
        rem  = negRem_i ? -work_i[2*W-1:W] : work_i[2*W-1:W];
        if (isMult_i) begin
            hi_o = prod[2*W-1:W];
            lo_o = prod[W-1:0];
        end else begin
            hi_o = rem;
            lo_o = quo;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO unit: shift-add multiply and restoring divide, one
// bit per cycle on magnitudes, followed by a sign-fix cycle that writes
// HI/LO. MTHI/MTLO write the registers directly from IDLE.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               isDiv_q;
    logic               sign_q;
    logic               negA_q;
    logic               negB_q;
    logic [WIDTH-1:0]   rawA_q;
    logic [WIDTH-1:0]   rawB_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] work_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               divZero_q;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTop;
    logic [WIDTH-1:0]   divDiff;
    logic               divOk;
    logic [2*WIDTH-1:0] work_d;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    // Operand magnitudes at issue and the next value of the iteration register
    always_comb begin
        absA    = (sign && A[WIDTH-1]) ? -A : A;
        absB    = (sign && B[WIDTH-1]) ? -B : B;
        mulSum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        divTop  = work_q[2*WIDTH-1:WIDTH-1];
        divOk   = (divTop >= {1'b0, opnd_q});
        divDiff = divTop[WIDTH-1:0] - opnd_q;
        if (isDiv_q) begin
            work_d = divOk ? {divDiff, work_q[WIDTH-2:0], 1'b1}
                           : {work_q[2*WIDTH-2:0], 1'b0};
        end else begin
            work_d = {mulSum, work_q[WIDTH-1:1]};
        end
    end

    md_sign_fix #(.W(WIDTH)) u_sign_fix (
        .isMult_i  (!isDiv_q),
        .negProd_i (sign_q && (negA_q ^ negB_q)),
        .negQuo_i  (sign_q && (negA_q ^ negB_q)),
        .negRem_i  (sign_q && negA_q),
        .work_i    (work_q),
        .hi_o      (fixHi),
        .lo_o      (fixLo)
    );

    // Controller FSM with registered HI/LO, done and div_zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isDiv_q   <= 1'b0;
            sign_q    <= 1'b0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            rawA_q    <= '0;
            rawB_q    <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op_e'(op))
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: begin
                                isDiv_q <= (md_op_e'(op) == OP_DIV);
                                sign_q  <= sign;
                                negA_q  <= A[WIDTH-1];
                                negB_q  <= B[WIDTH-1];
                                rawA_q  <= A;
                                rawB_q  <= B;
                                opnd_q  <= (md_op_e'(op) == OP_DIV) ? absB : absA;
                                work_q  <= {{WIDTH{1'b0}}, (md_op_e'(op) == OP_DIV) ? absA : absB};
                                cnt_q   <= '0;
                                state_q <= CALC;
                            end
                        endcase
                    end
                end
                CALC: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv_q && (rawB_q == '0)) begin
                        lo_q      <= '1;
                        hi_q      <= rawA_q;
                        divZero_q <= 1'b1;
                    end else begin
                        hi_q <= fixHi;
                        lo_q <= fixLo;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = divZero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
